// File: rtl/rate_gen_pkg.sv
// Shared constants and helpers for the programmable rate generator.
// The reset divisor yields a 4 kHz square wave from a 50 MHz system clock.
package rate_gen_pkg;

    localparam int CNT_W          = 16;
    localparam int DIV_4KHZ_50MHZ = 6250;
    localparam int MIN_DIV        = 2;

    // Half-periods below min_val cannot produce a distinct mid-phase strobe.
    function automatic logic [CNT_W-1:0] clamp_div(
        input logic [CNT_W-1:0] value,
        input logic [CNT_W-1:0] min_val
    );
        return (value < min_val) ? min_val : value;
    endfunction

endpackage

// File: rtl/rate_gen.sv
// Runtime-programmable rate generator: divided square wave plus rise/fall/mid strobes.
// A newly loaded divisor waits in a shadow register until the next half-period boundary.
module rate_gen #(
    parameter int CNT_W        = rate_gen_pkg::CNT_W,
    parameter int HALF_DIV_RST = rate_gen_pkg::DIV_4KHZ_50MHZ,
    parameter int MIN_DIV      = rate_gen_pkg::MIN_DIV
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             tick_mid,
    output logic             div_pending
);
    import rate_gen_pkg::*;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_act_q, div_act_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic [CNT_W-1:0] load_val;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             mid_q, mid_d;
    logic             wrap;
    logic             boundary;

    always_comb begin
        load_val   = clamp_div(div_in, CNT_W'(MIN_DIV));
        wrap       = en && (cnt_q == div_act_q - 1'b1);
        boundary   = 1'b0;
        cnt_d      = cnt_q;
        clk_d      = clk_q;
        div_act_d  = div_act_q;
        div_pend_d = div_pend_q;
        pend_d     = pend_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        mid_d      = 1'b0;

        if (sync) begin
            cnt_d    = '0;
            clk_d    = 1'b0;
            boundary = 1'b1;
        end else if (wrap) begin
            cnt_d    = '0;
            clk_d    = ~clk_q;
            rise_d   = ~clk_q;
            fall_d   = clk_q;
            boundary = 1'b1;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
            mid_d = clk_q && (cnt_d == (div_act_q >> 1));
        end

        // A load coinciding with a boundary bypasses the shadow register.
        if (boundary) begin
            if (div_load) begin
                div_act_d = load_val;
            end else if (pend_q) begin
                div_act_d = div_pend_q;
            end
            pend_d = 1'b0;
        end else if (div_load) begin
            div_pend_d = load_val;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            cnt_q      <= '0;
            clk_q      <= 1'b0;
            div_act_q  <= CNT_W'(HALF_DIV_RST);
            div_pend_q <= CNT_W'(HALF_DIV_RST);
            pend_q     <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            mid_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clk_q      <= clk_d;
            div_act_q  <= div_act_d;
            div_pend_q <= div_pend_d;
            pend_q     <= pend_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            mid_q      <= mid_d;
        end
    end

    assign clk_out     = clk_q;
    assign tick_rise   = rise_q;
    assign tick_fall   = fall_q;
    assign tick_mid    = mid_q;
    assign div_pending = pend_q;

endmodule

// File: tb/tb_rate_gen.sv
// Self-checking bench for rate_gen: directed scenarios plus randomized traffic
// compared against an elapsed-time reference model.
module tb_rate_gen;

    localparam int W = 16;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         sync = 1'b0;
    logic         div_load = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         clk_out, tick_rise, tick_fall, tick_mid, div_pending;

    int n_vec = 0;
    int n_err = 0;

    rate_gen #(
        .CNT_W       (W),
        .HALF_DIV_RST(rate_gen_pkg::DIV_4KHZ_50MHZ),
        .MIN_DIV     (2)
    ) dut (
        .clk_in     (clk_in),
        .rst        (rst),
        .en         (en),
        .sync       (sync),
        .div_in     (div_in),
        .div_load   (div_load),
        .clk_out    (clk_out),
        .tick_rise  (tick_rise),
        .tick_fall  (tick_fall),
        .tick_mid   (tick_mid),
        .div_pending(div_pending)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: tracks enabled time spent in the current half-period.
    bit m_level, m_rise, m_fall, m_mid, m_pend;
    int m_elapsed, m_div, m_pend_val;

    task automatic model_step();
        int ld;
        bit bnd;
        if (rst) begin
            m_level = 0; m_elapsed = 0; m_div = 6250; m_pend = 0;
            m_rise = 0; m_fall = 0; m_mid = 0;
        end else begin
            ld  = div_load ? ((int'(div_in) < 2) ? 2 : int'(div_in)) : -1;
            bnd = 0;
            m_rise = 0; m_fall = 0; m_mid = 0;
            if (sync) begin
                m_level = 0; m_elapsed = 0; bnd = 1;
            end else if (en) begin
                m_elapsed++;
                if (m_elapsed == m_div) begin
                    m_level = !m_level; m_elapsed = 0; bnd = 1;
                    m_rise = m_level; m_fall = !m_level;
                end else if (m_level && m_elapsed == m_div / 2) begin
                    m_mid = 1;
                end
            end
            if (bnd) begin
                if (ld >= 0) m_div = ld;
                else if (m_pend) m_div = m_pend_val;
                m_pend = 0;
            end else if (ld >= 0) begin
                m_pend = 1; m_pend_val = ld;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; sync = 0; div_load = 0; div_in = '0;
        tick(); tick();
        div_load = 1; div_in = 16'd9;
        tick();
        div_load = 0;
        n_vec++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL reset_clk_out: got %b expected 0", clk_out); end
        n_vec++; if (tick_rise !== 1'b0) begin n_err++; $display("FAIL reset_tick_rise: got %b expected 0", tick_rise); end
        n_vec++; if (tick_fall !== 1'b0) begin n_err++; $display("FAIL reset_tick_fall: got %b expected 0", tick_fall); end
        n_vec++; if (tick_mid !== 1'b0) begin n_err++; $display("FAIL reset_tick_mid: got %b expected 0", tick_mid); end
        n_vec++; if (div_pending !== 1'b0) begin n_err++; $display("FAIL reset_load_discard: got %b expected 0", div_pending); end
        $display("test_reset done");
    endtask

    task automatic test_default();
        rst = 0; en = 1;
        for (int c = 1; c <= 12500; c++) begin
            tick();
            n_vec++;
            if ((int'(tick_rise) + int'(tick_fall) + int'(tick_mid)) > 1) begin
                n_err++; $display("FAIL default_overlap: cycle %0d r/f/m %b%b%b expected at most one", c, tick_rise, tick_fall, tick_mid);
            end
            if (c == 6249) begin
                n_vec++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL default_pre_rise: got %b expected 0", clk_out); end
            end
            if (c == 6250) begin
                n_vec++; if (clk_out !== 1'b1) begin n_err++; $display("FAIL default_rise_clk: got %b expected 1", clk_out); end
                n_vec++; if (tick_rise !== 1'b1) begin n_err++; $display("FAIL default_tick_rise: got %b expected 1", tick_rise); end
            end
            if (c == 9374 || c == 9375) begin
                n_vec++;
                if (tick_mid !== (c == 9375)) begin n_err++; $display("FAIL default_tick_mid: cycle %0d got %b expected %b", c, tick_mid, c == 9375); end
            end
            if (c == 12500) begin
                n_vec++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL default_fall_clk: got %b expected 0", clk_out); end
                n_vec++; if (tick_fall !== 1'b1) begin n_err++; $display("FAIL default_tick_fall: got %b expected 1", tick_fall); end
            end
        end
        $display("test_default done");
    endtask

    task automatic test_reload();
        rst = 1; tick(); tick(); tick();
        rst = 0; en = 1;
        for (int c = 1; c <= 6290; c++) begin
            div_load = (c == 100);
            div_in   = 16'd4;
            tick();
            div_load = 0;
            if (c == 100 || c == 6249) begin
                n_vec++; if (div_pending !== 1'b1) begin n_err++; $display("FAIL reload_pending: cycle %0d got %b expected 1", c, div_pending); end
            end
            if (c == 6250) begin
                n_vec++; if (div_pending !== 1'b0) begin n_err++; $display("FAIL reload_applied: got %b expected 0", div_pending); end
            end
            if (c >= 6250) begin
                n_vec++;
                if (clk_out !== (((c - 6250) % 8) < 4)) begin n_err++; $display("FAIL reload_clk: cycle %0d got %b expected %b", c, clk_out, ((c - 6250) % 8) < 4); end
                n_vec++;
                if (tick_mid !== (((c - 6250) % 8) == 2)) begin n_err++; $display("FAIL reload_mid: cycle %0d got %b expected %b", c, tick_mid, ((c - 6250) % 8) == 2); end
            end
        end
        $display("test_reload done");
    endtask

    task automatic test_clamp_overwrite();
        int rises[$];
        div_load = 1; div_in = 16'd0;
        tick();
        div_load = 0;
        for (int i = 0; i < 200 && rises.size() < 3; i++) begin
            tick();
            if (tick_rise) rises.push_back(i);
        end
        n_vec++;
        if (rises.size() < 3) begin n_err++; $display("FAIL clamp_timeout: got %0d rises expected 3", rises.size()); end
        else if (rises[2] - rises[1] != 4) begin n_err++; $display("FAIL clamp_period: got %0d expected 4", rises[2] - rises[1]); end
        // Just after a rise with half-period 2: next edge is mid-count, the one after wraps.
        div_load = 1; div_in = 16'd5;
        tick();
        n_vec++; if (div_pending !== 1'b1) begin n_err++; $display("FAIL overwrite_pending: got %b expected 1", div_pending); end
        div_in = 16'd7;
        tick();
        div_load = 0;
        n_vec++; if (div_pending !== 1'b0) begin n_err++; $display("FAIL overwrite_at_wrap: got %b expected 0", div_pending); end
        rises.delete();
        for (int i = 0; i < 200 && rises.size() < 3; i++) begin
            tick();
            if (tick_rise) rises.push_back(i);
        end
        n_vec++;
        if (rises.size() < 3) begin n_err++; $display("FAIL overwrite_timeout: got %0d rises expected 3", rises.size()); end
        else if (rises[2] - rises[1] != 14) begin n_err++; $display("FAIL overwrite_period: got %0d expected 14", rises[2] - rises[1]); end
        $display("test_clamp_overwrite done");
    endtask

    task automatic test_sync();
        tick();
        div_load = 1; div_in = 16'd6;
        tick();
        div_load = 0;
        n_vec++; if (div_pending !== 1'b1) begin n_err++; $display("FAIL sync_pre_pending: got %b expected 1", div_pending); end
        n_vec++; if (clk_out !== 1'b1) begin n_err++; $display("FAIL sync_pre_high: got %b expected 1", clk_out); end
        sync = 1;
        tick();
        sync = 0;
        n_vec++; if (clk_out !== 1'b0) begin n_err++; $display("FAIL sync_clk: got %b expected 0", clk_out); end
        n_vec++; if (tick_fall !== 1'b0) begin n_err++; $display("FAIL sync_no_fall: got %b expected 0", tick_fall); end
        n_vec++; if (div_pending !== 1'b0) begin n_err++; $display("FAIL sync_pending: got %b expected 0", div_pending); end
        for (int i = 1; i <= 6; i++) begin
            tick();
            n_vec++;
            if (clk_out !== (i == 6) || tick_rise !== (i == 6)) begin
                n_err++; $display("FAIL sync_rise: step %0d clk/rise %b%b expected %b", i, clk_out, tick_rise, i == 6);
            end
        end
        $display("test_sync done");
    endtask

    task automatic test_en_gap();
        tick(); tick();
        en = 0;
        for (int i = 0; i < 37; i++) begin
            tick();
            n_vec++;
            if (clk_out !== 1'b1 || tick_rise || tick_fall || tick_mid) begin
                n_err++; $display("FAIL en_gap_freeze: step %0d clk %b r/f/m %b%b%b expected 1 000", i, clk_out, tick_rise, tick_fall, tick_mid);
            end
        end
        en = 1;
        tick();
        n_vec++; if (tick_mid !== 1'b1) begin n_err++; $display("FAIL en_gap_mid: got %b expected 1", tick_mid); end
        tick(); tick();
        n_vec++; if (clk_out !== 1'b1) begin n_err++; $display("FAIL en_gap_still_high: got %b expected 1", clk_out); end
        tick();
        n_vec++; if (clk_out !== 1'b0 || tick_fall !== 1'b1) begin n_err++; $display("FAIL en_gap_fall: clk/fall %b%b expected 01", clk_out, tick_fall); end
        $display("test_en_gap done");
    endtask

    task automatic test_reset_mid();
        div_load = 1; div_in = 16'd9;
        tick();
        div_load = 0;
        n_vec++; if (div_pending !== 1'b1) begin n_err++; $display("FAIL rstmid_pending: got %b expected 1", div_pending); end
        rst = 1;
        tick();
        rst = 0;
        n_vec++;
        if (clk_out !== 1'b0 || tick_rise || tick_fall || tick_mid || div_pending) begin
            n_err++; $display("FAIL rstmid_outputs: clk/r/f/m/p %b%b%b%b%b expected 00000", clk_out, tick_rise, tick_fall, tick_mid, div_pending);
        end
        for (int c = 1; c <= 6250; c++) begin
            tick();
            if (c == 6249 || c == 6250) begin
                n_vec++;
                if (clk_out !== (c == 6250)) begin n_err++; $display("FAIL rstmid_rise: cycle %0d got %b expected %b", c, clk_out, c == 6250); end
            end
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom % 500) == 0;
            en       = ($urandom % 8) != 0;
            sync     = ($urandom % 60) == 0;
            div_load = ($urandom % 15) == 0;
            div_in   = W'($urandom_range(0, 9));
            tick();
            n_vec++;
            if (clk_out !== m_level || tick_rise !== m_rise || tick_fall !== m_fall ||
                tick_mid !== m_mid || div_pending !== m_pend) begin
                n_err++;
                $display("FAIL random: step %0d clk/r/f/m/p got %b%b%b%b%b expected %b%b%b%b%b",
                         i, clk_out, tick_rise, tick_fall, tick_mid, div_pending,
                         m_level, m_rise, m_fall, m_mid, m_pend);
            end
        end
        rst = 0; sync = 0; div_load = 0;
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_default();
        test_reload();
        test_clamp_overwrite();
        test_sync();
        test_en_gap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
